// File: rtl/tetris_pkg.sv
// Shared Tetris board definitions.
//   COLS, ROWS, CELL_SHIFT : playfield geometry (cells, log2 cell size in px)
//   cell_code_t            : occupant code stored per board cell
//   cell_addr_t            : board RAM address, row*COLS+col
//   owner_t                : who issued the previous cycle's RAM access
package tetris_pkg;
  localparam int COLS       = 10;
  localparam int ROWS       = 20;
  localparam int CELL_SHIFT = 4;

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    I     = 3'd1,
    O     = 3'd2,
    T     = 3'd3,
    S     = 3'd4,
    Z     = 3'd5,
    J     = 3'd6,
    L     = 3'd7
  } cell_code_t;

  typedef logic [7:0] cell_addr_t;

  // A game write needs no response, so it is recorded as OWN_NONE.
  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_VIDEO   = 2'd1,
    OWN_GAME_RD = 2'd2
  } owner_t;
endpackage

// File: rtl/playfield_addr.sv
// Combinational pixel-to-cell mapping.
//   draw_x, draw_y : current pixel coordinates
//   in_field       : pixel lies inside the playfield rectangle
//   slot           : in_field and first pixel column of a cell (video fetch cycle)
//   addr           : board address row*COLS+col of the cell under the pixel
module playfield_addr
  import tetris_pkg::*;
#(
  parameter int COLS       = tetris_pkg::COLS,
  parameter int ROWS       = tetris_pkg::ROWS,
  parameter int CELL_SHIFT = tetris_pkg::CELL_SHIFT,
  parameter int ORIGIN_X   = 240,
  parameter int ORIGIN_Y   = 80
) (
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       in_field,
  output logic       slot,
  output cell_addr_t addr
);
  localparam logic [9:0] X_LO = 10'(ORIGIN_X);
  localparam logic [9:0] X_HI = 10'(ORIGIN_X + (COLS << CELL_SHIFT));
  localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + (ROWS << CELL_SHIFT));

  logic [9:0] dx;
  logic [9:0] dy;
  logic [9:0] col;
  logic [9:0] row;

  assign dx  = draw_x - X_LO;
  assign dy  = draw_y - Y_LO;
  assign col = dx >> CELL_SHIFT;
  assign row = dy >> CELL_SHIFT;

  assign in_field = (draw_x >= X_LO) && (draw_x < X_HI) &&
                    (draw_y >= Y_LO) && (draw_y < Y_HI);
  assign slot     = in_field && (dx[CELL_SHIFT-1:0] == '0);

  // row*10 as row*8 + row*2: the board is 10 cells wide, no multiplier.
  assign addr = cell_addr_t'((row << 3) + (row << 1) + col);
endmodule

// File: rtl/playfield_render_ctrl.sv
// Board RAM owner shared between the video fetch path and game logic.
//   Clk, Reset_n           : pixel clock, async active-low reset
//   DrawX, DrawY           : pixel coordinates from the VGA controller
//   is_block, cell_code    : colour mapper inputs, 2 cycles after the pixel
//   frame_tick             : pulse while DrawX=0, DrawY=480 is presented
//   mem_addr/we/wdata      : board RAM command; mem_rdata returns 1 cycle later
//   gm_req/we/addr/wdata   : game request; gm_gnt, gm_rvalid, gm_rdata responses
//
// Game handshake: gm_req is held with stable gm_we/gm_addr/gm_wdata until a
// cycle with gm_gnt=1; that cycle the request goes to RAM. gm_req still high on
// the following cycle is a new request. A granted read returns gm_rvalid=1 with
// gm_rdata exactly one cycle after its gm_gnt; gm_rdata holds otherwise.
module playfield_render_ctrl
  import tetris_pkg::*;
#(
  parameter int COLS       = tetris_pkg::COLS,
  parameter int ROWS       = tetris_pkg::ROWS,
  parameter int CELL_SHIFT = tetris_pkg::CELL_SHIFT,
  parameter int ORIGIN_X   = 240,
  parameter int ORIGIN_Y   = 80
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_block,
  output logic [2:0] cell_code,
  output logic       frame_tick,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [2:0] mem_wdata,
  input  logic [2:0] mem_rdata,
  input  logic       gm_req,
  input  logic       gm_we,
  input  logic [7:0] gm_addr,
  input  logic [2:0] gm_wdata,
  output logic       gm_gnt,
  output logic       gm_rvalid,
  output logic [2:0] gm_rdata
);
  // Reset asserts asynchronously and releases two clocks after Reset_n rises.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic       in_field;
  logic       slot;
  cell_addr_t vid_addr;

  playfield_addr #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .CELL_SHIFT (CELL_SHIFT),
    .ORIGIN_X   (ORIGIN_X),
    .ORIGIN_Y   (ORIGIN_Y)
  ) u_addr (
    .draw_x   (DrawX),
    .draw_y   (DrawY),
    .in_field (in_field),
    .slot     (slot),
    .addr     (vid_addr)
  );

  cell_addr_t addr_q;
  owner_t     owner_q;
  owner_t     owner_nxt;
  cell_code_t cell_d;
  logic [2:0] rdata_q;
  logic [1:0] in_field_d;
  logic       grant;

  // Video slots have absolute priority; any other cycle serves the game.
  assign grant = rst_n && gm_req && !slot;

  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = 3'd0;
    owner_nxt = OWN_NONE;
    if (rst_n) begin
      if (slot) begin
        mem_addr  = vid_addr;
        owner_nxt = OWN_VIDEO;
      end else if (gm_req) begin
        mem_addr  = gm_addr;
        mem_we    = gm_we;
        mem_wdata = gm_wdata;
        owner_nxt = gm_we ? OWN_NONE : OWN_GAME_RD;
      end
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      owner_q    <= OWN_NONE;
      cell_d     <= EMPTY;
      rdata_q    <= 3'd0;
      in_field_d <= 2'b00;
    end else begin
      addr_q     <= mem_addr;
      owner_q    <= owner_nxt;
      in_field_d <= {in_field_d[0], in_field};
      // Read data is only meaningful to whoever issued last cycle's access.
      if (owner_q == OWN_VIDEO)   cell_d  <= cell_code_t'(mem_rdata);
      if (owner_q == OWN_GAME_RD) rdata_q <= mem_rdata;
    end
  end

  assign gm_gnt     = grant;
  assign gm_rvalid  = (owner_q == OWN_GAME_RD);
  assign gm_rdata   = gm_rvalid ? mem_rdata : rdata_q;
  assign is_block   = in_field_d[1] && (cell_d != EMPTY);
  assign cell_code  = in_field_d[1] ? cell_d : EMPTY;
  assign frame_tick = rst_n && (DrawX == 10'd0) && (DrawY == 10'd480);
endmodule
